// File: rtl/router_pkg.sv
// Shared types and constants for the router packet framer.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam logic [1:0] INVALID_DEST = 2'd3;
  localparam int LEN_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } state_t;

  function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0] len,
                                                    input logic [1:0] dest);
    return {len, dest};
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload store: one synchronous write port, one combinational read port, no reset on storage.
module router_pkt_buf
  import router_pkg::*;
#(
  parameter int DEPTH = 63
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LEN_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LEN_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_reg[waddr] <= wdata;
  end

  // The read pointer can sit one past the last entry once the final byte is out.
  assign rdata = (raddr < LEN_W'(DEPTH)) ? mem_reg[raddr] : '0;

endmodule

// File: rtl/router_pkt_framer.sv
// Buffers a whole payload, then frames it to the router as header, payload, parity.
module router_pkt_framer
  import router_pkg::*;
#(
  parameter int MAX_LEN  = 63,
  parameter int IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_dest,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_ready,
  output logic              cmd_err,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              busy,
  output logic              packet_valid,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_done,
  output logic              tx_active
);

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  state_t            state_reg;
  logic [1:0]        dest_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  wr_ptr_reg;
  logic [LEN_W-1:0]  rd_ptr_reg;
  logic [DATA_W-1:0] parity_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              packet_valid_reg;
  logic [DATA_W-1:0] pkt_data_reg;
  logic              cmd_err_reg;
  logic              pkt_done_reg;
  logic [DATA_W-1:0] buf_rdata;
  logic              buf_we;

  assign buf_we = (state_reg == ST_FILL) && s_valid;

  router_pkt_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_reg),
    .wdata (s_data),
    .raddr (rd_ptr_reg),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= ST_IDLE;
      dest_reg         <= '0;
      len_reg          <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      parity_reg       <= '0;
      gap_cnt_reg      <= '0;
      packet_valid_reg <= 1'b0;
      pkt_data_reg     <= '0;
      cmd_err_reg      <= 1'b0;
      pkt_done_reg     <= 1'b0;
    end else begin
      cmd_err_reg  <= 1'b0;
      pkt_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_dest == INVALID_DEST || cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN)) begin
              cmd_err_reg <= 1'b1;
            end else begin
              dest_reg   <= cmd_dest;
              len_reg    <= cmd_len;
              parity_reg <= pack_header(cmd_len, cmd_dest);
              wr_ptr_reg <= '0;
              state_reg  <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (s_valid) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            parity_reg <= parity_reg ^ s_data;
            if (wr_ptr_reg == len_reg - 1'b1) begin
              state_reg        <= ST_HEADER;
              packet_valid_reg <= 1'b1;
              pkt_data_reg     <= pack_header(len_reg, dest_reg);
              rd_ptr_reg       <= '0;
            end
          end
        end
        ST_HEADER: begin
          if (!busy) begin
            pkt_data_reg <= buf_rdata;
            rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            state_reg    <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          // rd_ptr_reg counts bytes already presented; reaching len means the last one was just taken.
          if (!busy) begin
            if (rd_ptr_reg == len_reg) begin
              state_reg        <= ST_PARITY;
              packet_valid_reg <= 1'b0;
              pkt_data_reg     <= parity_reg;
            end else begin
              pkt_data_reg <= buf_rdata;
              rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (!busy) begin
            pkt_done_reg <= 1'b1;
            pkt_data_reg <= '0;
            gap_cnt_reg  <= '0;
            state_reg    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == GAP_W'(IDLE_GAP - 1)) state_reg <= ST_IDLE;
          else gap_cnt_reg <= gap_cnt_reg + 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state_reg == ST_IDLE);
  assign s_ready      = (state_reg == ST_FILL);
  assign tx_active    = (state_reg != ST_IDLE);
  assign packet_valid = packet_valid_reg;
  assign pkt_data     = pkt_data_reg;
  assign cmd_err      = cmd_err_reg;
  assign pkt_done     = pkt_done_reg;

endmodule

// File: doc/router_pkt_framer.md
Name: router_pkt_framer

Overview:
- Upstream packet source for the 1x3 router. Accepts a command (destination, length) and a payload byte stream from the host side, and buffers the complete payload.
- Then drives the router input contiguously: header, payload bytes, parity. Obeys the router's busy back-pressure and produces the byte-serial framing the router expects: packet_valid/data with XOR parity.

Parameters:
- MAX_LEN, 63, largest payload length (6-bit length field in header)
- IDLE_GAP, 2, idle cycles forced after a parity byte before the next command is accepted

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_dest  in  2  destination port 0..2
- cmd_len  in  6  payload length 1..MAX_LEN
- cmd_ready  out  1  framer can accept a command
- cmd_err  out  1  one-cycle pulse: command rejected
- s_valid  in  1  payload byte valid
- s_data  in  8  payload byte
- s_ready  out  1  framer accepts payload byte
- busy  in  1  router busy, hold current byte
- packet_valid  out  1  router packet_valid
- pkt_data  out  8  router datain
- pkt_done  out  1  one-cycle pulse when the parity byte is accepted
- tx_active  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset state: state=IDLE, and packet_valid, pkt_data, cmd_err, pkt_done and s_ready are all 0.
  - cmd_ready=1 and tx_active=0 (both decoded from IDLE).
  - Counters and the parity register are cleared. Buffer contents are don't-care.
- FSM states: IDLE, FILL, HEADER, PAYLOAD, PARITY, GAP. Outputs are registered; cmd_ready, s_ready and tx_active are decoded from state.
- IDLE:
  - Command accepted on a rising edge when cmd_valid=1 and cmd_ready=1.
  - If cmd_dest==3 or cmd_len==0: cmd_err=1 for the next cycle, stay in IDLE, no packet.
  - Otherwise: latch dest and len, set parity=header={len,dest}, set wr_ptr=0, go to FILL.
- FILL:
  - s_ready=1. Each edge with s_valid=1 writes buf[wr_ptr], then wr_ptr++ and parity^=s_data.
  - When the byte with wr_ptr==len-1 is written, go to HEADER and register packet_valid=1, pkt_data=header.
  - No output activity during FILL.
- HEADER/PAYLOAD:
  - The current byte is "accepted" at an edge where busy=0. When busy=1, pkt_data and packet_valid hold unchanged; no drop, no duplicate.
  - On acceptance, present buf[rd_ptr] next and increment rd_ptr.
  - After the last payload byte (rd_ptr==len) is accepted: go to PARITY with packet_valid=0 and pkt_data=parity.
- Packet timing: with busy=0 throughout, packet_valid is high for exactly len+1 consecutive cycles.
- PARITY:
  - Parity is presented with packet_valid=0 and held while busy=1.
  - On acceptance: pkt_done=1 for one cycle, pkt_data=0, go to GAP.
- GAP: count IDLE_GAP cycles with packet_valid=0 and pkt_data=0, then go to IDLE.
- Parity arithmetic: parity = header XOR all payload bytes, 8 bits. Pointers are 6 bits and never wrap because len ≤ 63.
- Ignored inputs:
  - cmd_valid is ignored outside IDLE.
  - s_valid is ignored outside FILL; s_ready is 0 there.
  - busy is ignored in IDLE, FILL and GAP.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous) and the partial packet is abandoned. The next command after release behaves normally.

Decomposition:
- router_pkg: FSM state enum, NUM_PORTS=3, INVALID_DEST=2'd3, LEN_W=6, DATA_W=8, header pack function {len,dest}.
- Sub-module router_pkt_buf: MAX_LEN×8 register array.
  - Synchronous write port (we, waddr, wdata); combinational read (raddr, rdata).
  - No reset on storage.

Test Plan:
1. Basic packet: dest=0, len=8, payload 0x01..0x08, busy=0 → pkt_data sequence 0x20, 0x01..0x08 with packet_valid=1 for 9 consecutive cycles; then 0x28 with packet_valid=0; pkt_done pulses once.
2. Back-pressure: same packet, busy=1 for 2 cycles while 0x03 is presented → 0x03 held 3 cycles, no drop or duplicate; parity still 0x28.
3. Rejected commands: cmd_dest=3, len=4 → cmd_err high 1 cycle, packet_valid stays 0, cmd_ready stays 1. Repeat with dest=1, len=0 → same response.
4. Maximum length: dest=2, len=63, payload all 0xFF → header 0xFE, 63×0xFF, parity 0x01; packet_valid high 64 cycles.
5. Source stalls: dest=1, len=5, s_valid toggling 1/0 during FILL → no packet_valid until the 5th byte is written; then header 0x15 plus 5 bytes contiguous.
6. Reset and back-to-back:
   - resetn=0 mid-PAYLOAD → packet_valid=0 and pkt_data=0 without waiting for clk; after release a new len=2 packet frames correctly.
   - With back-to-back commands, the second header appears no earlier than IDLE_GAP+2 cycles after pkt_done.
